// File: rtl/car_pkg.sv
// Shared speed/steering encodings and the speed-step rule for the robot car drive controller.
package car_pkg;

  typedef enum logic [2:0] {
    STOP = 3'd0,
    SLOW = 3'd1,
    MED  = 3'd2,
    HIGH = 3'd3,
    REV  = 3'd4
  } speed_t;

  typedef enum logic [1:0] {
    STRAIGHT = 2'd0,
    RIGHT    = 2'd1,
    LEFT     = 2'd2
  } steer_t;

  // Brake outranks accelerator; a brake held at standstill engages reverse.
  function automatic speed_t next_speed(speed_t cur, logic brake, logic acc);
    speed_t nxt;
    nxt = cur;
    if (brake) begin
      case (cur)
        HIGH:    nxt = MED;
        MED:     nxt = SLOW;
        SLOW:    nxt = STOP;
        STOP:    nxt = REV;
        default: nxt = STOP;
      endcase
    end else if (acc) begin
      case (cur)
        STOP:    nxt = SLOW;
        SLOW:    nxt = MED;
        MED:     nxt = HIGH;
        HIGH:    nxt = HIGH;
        REV:     nxt = REV;
        default: nxt = STOP;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Turn-indicator blink phase: BLINK_HALF cycles per phase, restartable so a new turn begins lamp-on.
module blink_gen #(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr || restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/control_car.sv
// Drive controller: speed FSM, steering register, engine/tail-light flags and blinking indicators.
module control_car
  import car_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key,
  input  logic       brake,
  input  logic       acc,
  input  logic [1:0] s,
  output logic       E,
  output logic       TL,
  output logic       RH,
  output logic       LH,
  output logic [2:0] M1,
  output logic [1:0] M2
);

  speed_t state, state_n;
  steer_t steer, steer_n;
  logic   key_v, brake_v, acc_v;
  logic   restart, phase;

  // Undriven (X/Z) commands behave as released.
  always_comb begin
    key_v   = (key === 1'b1);
    brake_v = (brake === 1'b1);
    acc_v   = (acc === 1'b1);
    steer_n = STRAIGHT;
    if (key_v && s == 2'd1) steer_n = RIGHT;
    if (key_v && s == 2'd2) steer_n = LEFT;
    state_n = key_v ? next_speed(state, brake_v, acc_v) : STOP;
    restart = (steer_n != steer);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= STOP;
      steer <= STRAIGHT;
      E     <= 1'b0;
      TL    <= 1'b0;
    end else begin
      state <= state_n;
      steer <= steer_n;
      E     <= key_v;
      TL    <= key_v && (brake_v || state_n == REV);
    end
  end

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk    (clk),
    .clr    (clr),
    .restart(restart),
    .phase  (phase)
  );

  // Indicators gate registered steering with the registered phase (phase 0 = lamp on).
  assign M1 = state;
  assign M2 = steer;
  assign RH = E && (steer == RIGHT) && !phase;
  assign LH = E && (steer == LEFT) && !phase;

endmodule

// File: tb/tb_control_car.sv
// Scoreboard bench for control_car: a level-based speed model predicts every cycle's outputs.
module tb_control_car;

  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       clr, key, brake, acc;
  logic [1:0] s;
  logic       E, TL, RH, LH;
  logic [2:0] M1;
  logic [1:0] M2;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];

  // Model state: speed level -1 (reverse) .. 3 (high), lamp age since last steering change.
  int         lvl = 0;
  int         age = 0;
  logic [1:0] m_m2 = 2'd0;
  logic       m_e = 1'b0, m_tl = 1'b0;

  control_car #(.BLINK_HALF(BH)) dut (
    .clk(clk), .clr(clr), .key(key), .brake(brake), .acc(acc), .s(s),
    .E(E), .TL(TL), .RH(RH), .LH(LH), .M1(M1), .M2(M2)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model_step(logic c, logic k, logic b, logic a, logic [1:0] ss);
    logic [1:0] new_m2;
    logic [2:0] m1;
    logic       on, rh, lh;
    if (!c) begin
      lvl = 0; age = 0; m_m2 = 2'd0; m_e = 1'b0; m_tl = 1'b0;
    end else begin
      new_m2 = (k && (ss == 2'd1 || ss == 2'd2)) ? ss : 2'd0;
      if (!k)                         lvl = 0;
      else if (b)                     lvl = (lvl > 0) ? lvl - 1 : ((lvl == 0) ? -1 : 0);
      else if (a && lvl >= 0 && lvl < 3) lvl = lvl + 1;
      m_e  = k;
      m_tl = k && (b || lvl < 0);
      age  = (new_m2 != m_m2) ? 0 : age + 1;
      m_m2 = new_m2;
    end
    m1 = (lvl < 0) ? 3'd4 : 3'(lvl);
    on = ((age / BH) % 2) == 0;
    rh = m_e && m_m2 == 2'd1 && on;
    lh = m_e && m_m2 == 2'd2 && on;
    return {m_e, m_tl, rh, lh, m1, m_m2};
  endfunction

  task automatic step(input logic c, input logic k, input logic b, input logic a,
                      input logic [1:0] ss);
    clr = c; key = k; brake = b; acc = a; s = ss;
    @(posedge clk);
    exp_q.push_back(model_step(c, k, b, a, ss));
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared #1 after the edge.
  always @(posedge clk) begin
    logic [8:0] want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("scoreboard {E,TL,RH,LH,M1,M2}", {E, TL, RH, LH, M1, M2}, want);
    end
  end

  initial begin
    logic [1:0] cur_s;
    int         waited;
    clr = 1'b0; key = 1'b1; brake = 1'b0; acc = 1'b1; s = 2'd0;
    @(negedge clk);

    step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
    check("reset outputs", {E, TL, RH, LH, M1, M2}, 9'd0);
    step(1, 1, 0, 1, 0);
    check("first after reset M1,E", {M1, E}, {3'd1, 1'b1});

    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
    check("accel saturates M1", {6'd0, M1}, 9'd3);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    check("hold at HIGH", {6'd0, M1}, 9'd3);

    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    check("brake into REV M1,TL", {5'd0, M1, TL}, {5'd0, 3'd4, 1'b1});
    step(1, 1, 0, 1, 0);
    check("acc in REV M1,TL", {5'd0, M1, TL}, {5'd0, 3'd4, 1'b1});
    step(1, 1, 1, 0, 0);
    check("brake leaves REV", {6'd0, M1}, 9'd0);

    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    check("brake beats acc", {6'd0, M1}, 9'd1);

    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 2);
    check("switch to left M2,RH,LH", {5'd0, M2, RH, LH}, {5'd0, 2'd2, 1'b0, 1'b1});
    step(1, 1, 0, 0, 3);
    check("s=3 straight M2,RH,LH", {5'd0, M2, RH, LH}, 9'd0);

    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 2);
    step(1, 0, 0, 1, 2);
    check("key off", {E, TL, RH, LH, M1, M2}, 9'd0);

    cur_s = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) cur_s = 2'($urandom_range(3));
      step($urandom_range(31) != 0, $urandom_range(7) != 0,
           $urandom_range(3) == 0, $urandom_range(1) == 0, cur_s);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
